lcd_line_arbiter: RTL and testbench

Shares the single character-LCD byte-write controller (iDATA/iRS/iStart/oDone handshake) between two independent message sources, e.g. the AES status display and the key/ciphertext display. After reset it issues the HD44780 initialisation sequence once. It then grants whole-line write transactions round-robin, each transaction being one DDRAM-address command plus 16 characters. It sits between the message producers and the byte-level LCD controller and replaces fixed-message sequencing.

---
 rtl/lcd_line_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_lcd_line_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_line_arbiter.sv
`default_nettype none
// =============================================================================
// lcd_line_arbiter : round-robin whole-line arbiter in front of a byte-level
//                    HD44780 write controller; replays the init sequence after reset.
// Revision 1.0
// =============================================================================
module lcd_line_arbiter #(
   parameter int DLY_CYCLES = 262142
) (
   input  logic         iCLK,
   input  logic         iRST_N,
   input  logic         iREQ0,
   input  logic         iREQ1,
   input  logic         iLINE0,
   input  logic         iLINE1,
   input  logic [127:0] iMSG0,
   input  logic [127:0] iMSG1,
   output logic         oACK0,
   output logic         oACK1,
   output logic         oDONE0,
   output logic         oDONE1,
   output logic [7:0]   oLCD_DATA,
   output logic         oLCD_RS,
   output logic         oLCD_Start,
   input  logic         iLCD_Done,
   output logic         oINIT_DONE,
   output logic         oBUSY
);

   localparam int CNT_W = ($clog2(DLY_CYCLES + 1) > 18) ? $clog2(DLY_CYCLES + 1) : 18;
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_CYCLES - 1);

   typedef enum logic [3:0] {
      INIT_ISSUE = 4'd0,
      INIT_WAIT  = 4'd1,
      INIT_DLY   = 4'd2,
      IDLE       = 4'd3,
      ISSUE      = 4'd4,
      WAIT       = 4'd5,
      DLY        = 4'd6,
      NEXT       = 4'd7
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         init_idx_q, init_idx_d;
   logic [4:0]         byte_idx_q, byte_idx_d;
   logic [CNT_W-1:0]   dly_cnt_q, dly_cnt_d;
   logic [127:0]       buf_q, buf_d;
   logic               line_q, line_d;
   logic               owner_q, owner_d;
   logic               last_grant_q, last_grant_d;
   logic [7:0]         lcd_data_q, lcd_data_d;
   logic               lcd_rs_q, lcd_rs_d;
   logic               lcd_start_q, lcd_start_d;
   logic               ack0_q, ack0_d, ack1_q, ack1_d;
   logic               done0_q, done0_d, done1_q, done1_d;
   logic               init_done_q, init_done_d;
   logic               busy_q, busy_d;

   logic [7:0]         init_byte;
   logic [3:0]         char_sel;
   logic [7:0]         raw_char;
   logic [7:0]         tx_char;
   logic [7:0]         cmd_byte;

   always_comb begin
      init_byte = 8'h38;
      case (init_idx_q)
         2'd0:    init_byte = 8'h38;
         2'd1:    init_byte = 8'h0C;
         2'd2:    init_byte = 8'h01;
         default: init_byte = 8'h06;
      endcase
   end

   // Index k (1..16) selects buf[127-8(k-1) -: 8]; index 0 wraps harmlessly to slot 0.
   assign char_sel = 4'(5'd16 - byte_idx_q);
   assign raw_char = buf_q[{char_sel, 3'b000} +: 8];
   assign tx_char  = (raw_char == 8'h00) ? 8'h3F : raw_char;
   assign cmd_byte = {1'b1, line_q, 6'b000000};

   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      byte_idx_d   = byte_idx_q;
      dly_cnt_d    = dly_cnt_q;
      buf_d        = buf_q;
      line_d       = line_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      lcd_data_d   = lcd_data_q;
      lcd_rs_d     = lcd_rs_q;
      lcd_start_d  = lcd_start_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      init_done_d  = init_done_q;

      case (state_q)
         INIT_ISSUE: begin
            lcd_data_d  = init_byte;
            lcd_rs_d    = 1'b0;
            lcd_start_d = 1'b1;
            state_d     = INIT_WAIT;
         end
         INIT_WAIT: begin
            if (iLCD_Done) begin
               lcd_start_d = 1'b0;
               dly_cnt_d   = '0;
               state_d     = INIT_DLY;
            end
         end
         INIT_DLY: begin
            if (dly_cnt_q == DLY_LAST) begin
               if (init_idx_q == 2'd3) begin
                  init_done_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  init_idx_d = init_idx_q + 2'd1;
                  state_d    = INIT_ISSUE;
               end
            end else begin
               dly_cnt_d = dly_cnt_q + 1'b1;
            end
         end
         IDLE: begin
            // Port 0 wins unless port 1 also asks and port 0 was served last.
            if (iREQ0 && (!iREQ1 || last_grant_q)) begin
               buf_d        = iMSG0;
               line_d       = iLINE0;
               owner_d      = 1'b0;
               last_grant_d = 1'b0;
               ack0_d       = 1'b1;
               byte_idx_d   = 5'd0;
               state_d      = ISSUE;
            end else if (iREQ1) begin
               buf_d        = iMSG1;
               line_d       = iLINE1;
               owner_d      = 1'b1;
               last_grant_d = 1'b1;
               ack1_d       = 1'b1;
               byte_idx_d   = 5'd0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (byte_idx_q == 5'd0) begin
               lcd_data_d = cmd_byte;
               lcd_rs_d   = 1'b0;
            end else begin
               lcd_data_d = tx_char;
               lcd_rs_d   = 1'b1;
            end
            lcd_start_d = 1'b1;
            state_d     = WAIT;
         end
         WAIT: begin
            if (iLCD_Done) begin
               lcd_start_d = 1'b0;
               dly_cnt_d   = '0;
               state_d     = DLY;
            end
         end
         DLY: begin
            if (dly_cnt_q == DLY_LAST) begin
               state_d = NEXT;
            end else begin
               dly_cnt_d = dly_cnt_q + 1'b1;
            end
         end
         NEXT: begin
            if (byte_idx_q == 5'd16) begin
               done0_d = ~owner_q;
               done1_d = owner_q;
               state_d = IDLE;
            end else begin
               byte_idx_d = byte_idx_q + 5'd1;
               state_d    = ISSUE;
            end
         end
         default: state_d = INIT_ISSUE;
      endcase

      // Registered view of "not idle" so every output reads 0 while in reset.
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q      <= INIT_ISSUE;
         init_idx_q   <= 2'd0;
         byte_idx_q   <= 5'd0;
         dly_cnt_q    <= '0;
         buf_q        <= '0;
         line_q       <= 1'b0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         lcd_data_q   <= 8'h00;
         lcd_rs_q     <= 1'b0;
         lcd_start_q  <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         init_done_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         byte_idx_q   <= byte_idx_d;
         dly_cnt_q    <= dly_cnt_d;
         buf_q        <= buf_d;
         line_q       <= line_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         lcd_data_q   <= lcd_data_d;
         lcd_rs_q     <= lcd_rs_d;
         lcd_start_q  <= lcd_start_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         init_done_q  <= init_done_d;
         busy_q       <= busy_d;
      end
   end

   assign oACK0      = ack0_q;
   assign oACK1      = ack1_q;
   assign oDONE0     = done0_q;
   assign oDONE1     = done1_q;
   assign oLCD_DATA  = lcd_data_q;
   assign oLCD_RS    = lcd_rs_q;
   assign oLCD_Start = lcd_start_q;
   assign oINIT_DONE = init_done_q;
   assign oBUSY      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_line_arbiter.sv
`default_nettype none
// tb_lcd_line_arbiter : table vectors, hand sequences and randomized rounds
//                       against a transaction-level model of lcd_line_arbiter.
module tb_lcd_line_arbiter;

   localparam int D = 4;

   logic         iCLK = 1'b0;
   logic         iRST_N = 1'b0;
   logic         iREQ0, iREQ1;
   logic         line0 = 1'b0, line1 = 1'b0;
   logic [127:0] msg0 = '0, msg1 = '0;
   logic [127:0] iMSG0;
   logic         oACK0, oACK1, oDONE0, oDONE1;
   logic [7:0]   oLCD_DATA;
   logic         oLCD_RS, oLCD_Start, iLCD_Done, oINIT_DONE, oBUSY;

   // Request bookkeeping: main thread raises ids, monitor marks them acknowledged.
   int  req0_id = 0, req1_id = 0, acked0_id = 0, acked1_id = 0;
   bit  req0_on = 0, req1_on = 0;
   bit  scramble0 = 0;
   int  hold_acks = 0;

   assign iREQ0 = req0_on && (acked0_id != req0_id);
   assign iREQ1 = req1_on && (acked1_id != req1_id);
   assign iMSG0 = (scramble0 && acked0_id == req0_id) ? '1 : msg0;

   always #5 iCLK = ~iCLK;

   lcd_line_arbiter #(.DLY_CYCLES(D)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N),
      .iREQ0(iREQ0), .iREQ1(iREQ1),
      .iLINE0(line0), .iLINE1(line1),
      .iMSG0(iMSG0), .iMSG1(msg1),
      .oACK0(oACK0), .oACK1(oACK1),
      .oDONE0(oDONE0), .oDONE1(oDONE1),
      .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS),
      .oLCD_Start(oLCD_Start), .iLCD_Done(iLCD_Done),
      .oINIT_DONE(oINIT_DONE), .oBUSY(oBUSY)
   );

   int tests = 0, fails = 0;
   int cyc = 0;
   int lat = 3;
   int model_last = 1;
   logic [8:0] byte_log[$];
   logic [8:0] exp_bytes[$];
   int ack_log[$], ack_cyc[$], done_log[$], done_cyc[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Controller model plus event monitor, sampling 1 time unit after each edge.
   initial begin
      int         ccnt;
      int         done_edge;
      logic       prev_start;
      logic [8:0] cur_byte;
      ccnt = 0; done_edge = 0; prev_start = 0; cur_byte = '0;
      iLCD_Done = 1'b0;
      forever begin
         @(posedge iCLK); #1;
         cyc++;
         if (!iRST_N) begin
            iLCD_Done = 1'b0; ccnt = 0; prev_start = 0;
         end else begin
            if (oLCD_Start && !prev_start) begin
               cur_byte = {oLCD_RS, oLCD_DATA};
               byte_log.push_back(cur_byte);
               if (oLCD_RS) check("done_to_start_gap", 128'(cyc - done_edge), 128'(D + 2));
            end
            if (oLCD_Start) begin
               check("start_window_stable", {oLCD_RS, oLCD_DATA}, cur_byte);
               if (!iLCD_Done) begin
                  ccnt++;
                  if (ccnt >= lat) begin
                     iLCD_Done = 1'b1; ccnt = 0; done_edge = cyc + 1;
                  end
               end else iLCD_Done = 1'b0;
            end else iLCD_Done = 1'b0;
            prev_start = oLCD_Start;

            if (oACK0 || oACK1 || oDONE0 || oDONE1)
               check("ack_done_same_port", (oACK0 & oDONE0) | (oACK1 & oDONE1), 0);
            if (oDONE0 || oDONE1) begin
               done_log.push_back(oDONE1 ? 1 : 0);
               done_cyc.push_back(cyc);
            end
            if (oACK0 || oACK1) begin
               check("single_ack", oACK0 & oACK1, 0);
               ack_log.push_back(oACK1 ? 1 : 0);
               ack_cyc.push_back(cyc);
               if (hold_acks == 0) begin
                  if (oACK0) acked0_id = req0_id;
                  if (oACK1) acked1_id = req1_id;
               end else if (ack_log.size() >= hold_acks) begin
                  acked0_id = req0_id;
                  acked1_id = req1_id;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge iCLK); #2; end
   endtask

   task automatic clear_logs();
      byte_log.delete(); exp_bytes.delete();
      ack_log.delete(); ack_cyc.delete(); done_log.delete(); done_cyc.delete();
   endtask

   function automatic void add_txn(input logic line, input logic [127:0] msg);
      logic [7:0] ch;
      exp_bytes.push_back({1'b0, line ? 8'hC0 : 8'h80});
      for (int k = 0; k < 16; k++) begin
         ch = msg[127 - 8*k -: 8];
         exp_bytes.push_back({1'b1, (ch == 8'h00) ? 8'h3F : ch});
      end
   endfunction

   function automatic logic [127:0] rand_msg();
      logic [127:0] m;
      for (int k = 0; k < 16; k++)
         m[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      return m;
   endfunction

   task automatic cmp_bytes(input string name);
      check({name, "_byte_count"}, 128'(byte_log.size()), 128'(exp_bytes.size()));
      for (int i = 0; i < exp_bytes.size() && i < byte_log.size(); i++)
         check($sformatf("%s_byte%0d", name, i), byte_log[i], exp_bytes[i]);
   endtask

   task automatic check_grants(input string name, input int exp_q[$]);
      check({name, "_ack_count"}, 128'(ack_log.size()), 128'(exp_q.size()));
      check({name, "_done_count"}, 128'(done_log.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < ack_log.size(); i++)
         check($sformatf("%s_ack%0d_port", name, i), 128'(ack_log[i]), 128'(exp_q[i]));
      for (int i = 0; i < exp_q.size() && i < done_log.size(); i++)
         check($sformatf("%s_done%0d_port", name, i), 128'(done_log[i]), 128'(exp_q[i]));
   endtask

   task automatic wait_dones(input int n, input int budget);
      int k = 0;
      while (done_log.size() < n && k < budget) begin tick(1); k++; end
      check("dones_within_budget", 128'(done_log.size()), 128'(n));
      tick(3);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},  oLCD_DATA, 8'h00);
      check({tag, "_rs"},    oLCD_RS, 0);
      check({tag, "_start"}, oLCD_Start, 0);
      check({tag, "_ack"},   {oACK0, oACK1}, 0);
      check({tag, "_done"},  {oDONE0, oDONE1}, 0);
      check({tag, "_init"},  oINIT_DONE, 0);
      check({tag, "_busy"},  oBUSY, 0);
   endtask

   task automatic wait_init(input string tag);
      int k = 0;
      while (!oINIT_DONE && k < 500) begin tick(1); k++; end
      check({tag, "_init_done"}, oINIT_DONE, 1);
   endtask

   typedef struct {
      bit r0; bit r1; bit l0; bit l1;
      logic [127:0] m0; logic [127:0] m1;
      int first; int n;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int order[$];
      int k;
      logic [127:0] lm;

      vecs[0] = '{0, 1, 0, 1, '0, "HELLO WORLD 1234", 1, 1};
      vecs[1] = '{1, 0, 0, 0, '0, '0, 0, 1};
      vecs[2] = '{1, 1, 1, 0, "ABCDEFGHIJKLMNOP", 128'h41004200430044004500460047004800, 1, 2};
      vecs[3] = '{0, 1, 0, 0, '0, "0123456789abcdef", 1, 1};

      // Reset, then init with port 0 already requesting.
      req0_id++; req0_on = 1;
      #23;
      check_reset_outputs("reset");
      tick(2);
      iRST_N = 1'b1;
      clear_logs();
      wait_init("init");
      check("no_ack_during_init", 128'(ack_log.size()), 0);
      req0_on = 0;
      exp_bytes = '{9'h038, 9'h00C, 9'h001, 9'h006};
      cmp_bytes("init");
      tick(4);
      check("idle_after_withdraw_ack", 128'(ack_log.size()), 0);
      check("idle_busy", oBUSY, 0);

      // Table vectors
      for (int v = 0; v < 4; v++) begin
         clear_logs();
         msg0 = vecs[v].m0; msg1 = vecs[v].m1;
         line0 = vecs[v].l0; line1 = vecs[v].l1;
         if (vecs[v].r0) begin req0_id++; req0_on = 1; end
         if (vecs[v].r1) begin req1_id++; req1_on = 1; end
         wait_dones(vecs[v].n, 3000);
         req0_on = 0; req1_on = 0;
         order.delete();
         for (int i = 0; i < vecs[v].n; i++) begin
            k = (i == 0) ? vecs[v].first : 1 - vecs[v].first;
            order.push_back(k);
            add_txn(k ? vecs[v].l1 : vecs[v].l0, k ? vecs[v].m1 : vecs[v].m0);
            model_last = k;
         end
         check_grants($sformatf("vec%0d", v), order);
         cmp_bytes($sformatf("vec%0d", v));
      end

      // Sustained dual requests alternate, one idle cycle between transactions.
      clear_logs();
      msg0 = "PORT ZERO STATUS"; msg1 = "PORT ONE CIPHER!";
      line0 = 0; line1 = 1;
      hold_acks = 4;
      req0_id++; req0_on = 1; req1_id++; req1_on = 1;
      wait_dones(4, 6000);
      req0_on = 0; req1_on = 0; hold_acks = 0;
      order = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) add_txn(order[i] ? line1 : line0, order[i] ? msg1 : msg0);
      model_last = 1;
      check_grants("sustained", order);
      cmp_bytes("sustained");
      for (int i = 1; i < 4 && i < ack_cyc.size() && i <= done_cyc.size(); i++)
         check($sformatf("idle_gap%0d", i), 128'(ack_cyc[i] - done_cyc[i-1]), 1);

      // Latch after ACK; a port-1 request withdrawn before grant has no effect.
      clear_logs();
      lm = "LATCHED MESSAGE!";
      msg0 = lm; line0 = 1; scramble0 = 1;
      req0_id++; req0_on = 1;
      k = 0;
      while (ack_log.size() == 0 && k < 100) begin tick(1); k++; end
      tick(5);
      req1_id++; req1_on = 1;
      tick(20);
      req1_on = 0;
      wait_dones(1, 3000);
      req0_on = 0; scramble0 = 0;
      add_txn(1'b1, lm);
      model_last = 0;
      check_grants("latch", '{0});
      cmp_bytes("latch");

      // Randomized rounds against the transaction-level model.
      for (int r = 0; r < 8; r++) begin
         int sel;
         clear_logs();
         lat = $urandom_range(1, 3);
         sel = $urandom_range(1, 3);
         msg0 = rand_msg(); msg1 = rand_msg();
         line0 = 1'($urandom_range(0, 1)); line1 = 1'($urandom_range(0, 1));
         order.delete();
         if (sel == 3) begin
            order.push_back(1 - model_last);
            order.push_back(model_last);
         end else order.push_back(sel - 1);
         if (sel[0]) begin req0_id++; req0_on = 1; end
         if (sel[1]) begin req1_id++; req1_on = 1; end
         wait_dones(order.size(), 3000);
         req0_on = 0; req1_on = 0;
         foreach (order[i]) add_txn(order[i] ? line1 : line0, order[i] ? msg1 : msg0);
         model_last = order[order.size() - 1];
         check_grants($sformatf("rand%0d", r), order);
         cmp_bytes($sformatf("rand%0d", r));
      end
      lat = 3;

      // Asynchronous reset in the middle of character 7.
      clear_logs();
      msg0 = rand_msg(); line0 = 0;
      req0_id++; req0_on = 1;
      k = 0;
      while (byte_log.size() < 8 && k < 500) begin tick(1); k++; end
      check("midreset_reached_char7", 128'(byte_log.size()), 8);
      req0_on = 0;
      #3 iRST_N = 1'b0;
      #1 check_reset_outputs("midreset");
      tick(3);
      byte_log.delete();
      iRST_N = 1'b1;
      tick(1);
      check("midreset_init_cleared", oINIT_DONE, 0);
      wait_init("midreset");
      exp_bytes = '{9'h038, 9'h00C, 9'h001, 9'h006};
      cmp_bytes("midreset_init");
      tick(5);
      check("midreset_no_done", 128'(done_log.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
